// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// Word size, NOP encoding, opcodes, fetch state enum, PC helper.
package cpu_defs;

  localparam int XLEN = 16;

  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_JR   = 4'hC;
  localparam logic [3:0] OP_EXEC = 4'hD;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_e;

  // 16-bit modulo increment; FFFF wraps to 0000.
  function automatic logic [XLEN-1:0] inc16(
    input logic [XLEN-1:0] a
  );
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC select for the fetch stage plus the +1 adders.
// Ports: pc_i/ret_pc_i/redirect_pc_i candidates, one-hot-or-none
// selects sel_*_i, link_base_i; pc_d_o next PC, link_o = link_base_i+1.
module fetch_pc_gen
  import cpu_defs::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] ret_pc_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            sel_redirect_i,
  input  logic            sel_ret_i,
  input  logic            sel_seq_i,
  input  logic [XLEN-1:0] link_base_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] link_o
);

  always_comb begin
    pc_d_o = pc_i;
    unique case (1'b1)
      sel_redirect_i: pc_d_o = redirect_pc_i;
      sel_ret_i:      pc_d_o = ret_pc_i;
      sel_seq_i:      pc_d_o = inc16(pc_i);
      default:        pc_d_o = pc_i;
    endcase
  end

  assign link_o = inc16(link_base_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request, IF/ID latch, EXEC.
// Ports: clk/rst, hold, redirect(+pc), exec_req(+pc), imem_*, if_*.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        exec_req,
  input  logic [15:0] exec_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_link,
  output logic        if_valid
);

  import cpu_defs::*;

  fetch_state_e state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ret_pc_q, ret_pc_d;
  logic [15:0] exec_addr_q, exec_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;

  logic in_fetch;
  logic take_exec;
  logic sel_ret;
  logic sel_seq;

  assign in_fetch  = (state_q == FETCH);
  assign take_exec = !redirect && exec_req && in_fetch;
  assign sel_ret   = !redirect && !hold && !in_fetch
                   && imem_ready;
  assign sel_seq   = !redirect && !take_exec && !hold
                   && in_fetch && imem_ready;

  fetch_pc_gen u_pc_gen (
    .pc_i          (pc_q),
    .ret_pc_i      (ret_pc_q),
    .redirect_pc_i (redirect_pc),
    .sel_redirect_i(redirect),
    .sel_ret_i     (sel_ret),
    .sel_seq_i     (sel_seq),
    .link_base_i   (ifpc_q),
    .pc_d_o        (pc_d),
    .link_o        (if_link)
  );

  // Request is withheld only while reset is applied.
  assign imem_req  = !rst;
  assign imem_addr = in_fetch ? pc_q : exec_addr_q;

  always_comb begin
    state_d     = state_q;
    ret_pc_d    = ret_pc_q;
    exec_addr_d = exec_addr_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    valid_d     = valid_q;
    if (redirect) begin
      state_d = FETCH;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (take_exec) begin
      ret_pc_d    = pc_q;
      exec_addr_d = exec_pc;
      state_d     = EXEC;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
    end else if (hold) begin
      state_d = state_q;
    end else if (imem_ready) begin
      instr_d = imem_rdata;
      ifpc_d  = in_fetch ? pc_q : exec_addr_q;
      valid_d = 1'b1;
      state_d = FETCH;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ret_pc_q    <= 16'h0000;
      exec_addr_q <= 16'h0000;
      instr_q     <= NOP_INSTR;
      ifpc_q      <= 16'h0000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ret_pc_q    <= ret_pc_d;
      exec_addr_q <= exec_addr_d;
      instr_q     <= instr_d;
      ifpc_q      <= ifpc_d;
      valid_q     <= valid_d;
    end
  end

  assign if_instr = instr_q;
  assign if_pc    = ifpc_q;
  assign if_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus wrap/reset cases.
// Memory returns 16'h1000+addr combinationally.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, redirect, exec_req, imem_ready;
  logic [15:0] redirect_pc, exec_pc;
  logic        imem_req;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_instr, if_pc, if_link;
  logic        if_valid;

  logic        w_rst, w_hold, w_redirect, w_exec_req, w_ready;
  logic [15:0] w_redirect_pc, w_exec_pc;
  logic        w_req;
  logic [15:0] w_addr, w_rdata;
  logic [15:0] w_instr, w_pc, w_link;
  logic        w_valid;

  assign imem_rdata = 16'h1000 + imem_addr;
  assign w_rdata    = 16'h1000 + w_addr;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .hold(hold),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .exec_req(exec_req), .exec_pc(exec_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .if_link(if_link), .if_valid(if_valid)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(w_rst), .hold(w_hold),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .exec_req(w_exec_req), .exec_pc(w_exec_pc),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_ready(w_ready),
    .if_instr(w_instr), .if_pc(w_pc),
    .if_link(w_link), .if_valid(w_valid)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        hold;
    logic        redir;
    logic [15:0] rpc;
    logic        exec;
    logic [15:0] epc;
    logic        ready;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] addr;
  } vec_t;

  vec_t tv[30];

  function automatic vec_t mk(
    input logic h, input logic r, input logic [15:0] rp,
    input logic e, input logic [15:0] ep, input logic rdy,
    input logic v, input logic [15:0] p, input logic [15:0] a);
    vec_t t;
    t.hold = h; t.redir = r; t.rpc = rp;
    t.exec = e; t.epc = ep; t.ready = rdy;
    t.valid = v; t.pc = p; t.addr = a;
    return t;
  endfunction

  initial begin
    //          hold rd rpc     ex epc     rdy v pc       addr
    tv[0]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0000, 16'h0001);
    tv[1]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0001, 16'h0002);
    tv[2]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0002, 16'h0003);
    tv[3]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0003, 16'h0004);
    tv[4]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0004, 16'h0005);
    tv[5]  = mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 16'h0005);
    tv[6]  = mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 16'h0005);
    tv[7]  = mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 16'h0005);
    tv[8]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0005, 16'h0006);
    tv[9]  = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0006, 16'h0007);
    tv[10] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0007, 16'h0008);
    tv[11] = mk(1, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0007, 16'h0008);
    tv[12] = mk(1, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0007, 16'h0008);
    tv[13] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0008, 16'h0009);
    tv[14] = mk(0, 1, 16'h0040, 0, 16'h0, 1, 0, 16'h0, 16'h0040);
    tv[15] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0040, 16'h0041);
    tv[16] = mk(0, 1, 16'h0010, 0, 16'h0, 1, 0, 16'h0, 16'h0010);
    tv[17] = mk(0, 0, 16'h0, 1, 16'h0200, 1, 0, 16'h0, 16'h0200);
    tv[18] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0200, 16'h0010);
    tv[19] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0010, 16'h0011);
    tv[20] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0011, 16'h0012);
    tv[21] = mk(0, 1, 16'h0030, 1, 16'h0300, 1, 0, 16'h0, 16'h0030);
    tv[22] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0030, 16'h0031);
    tv[23] = mk(1, 1, 16'h0050, 0, 16'h0, 1, 0, 16'h0, 16'h0050);
    tv[24] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0050, 16'h0051);
    tv[25] = mk(0, 0, 16'h0, 1, 16'h0400, 1, 0, 16'h0, 16'h0400);
    tv[26] = mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 16'h0400);
    tv[27] = mk(0, 0, 16'h0, 1, 16'h0500, 0, 0, 16'h0, 16'h0400);
    tv[28] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0400, 16'h0051);
    tv[29] = mk(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0051, 16'h0052);

    rst = 1; hold = 0; redirect = 0; redirect_pc = 0;
    exec_req = 0; exec_pc = 0; imem_ready = 0;
    w_rst = 1; w_hold = 0; w_redirect = 0; w_redirect_pc = 0;
    w_exec_req = 0; w_exec_pc = 0; w_ready = 1;

    step();
    chk("rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'h0000);
    rst = 0;
    #1;
    chk("rst_req_rel", {15'd0, imem_req}, 16'h0001);
    chk("rst_addr", imem_addr, 16'h0000);

    for (int i = 0; i < 30; i++) begin
      hold = tv[i].hold; redirect = tv[i].redir;
      redirect_pc = tv[i].rpc; exec_req = tv[i].exec;
      exec_pc = tv[i].epc; imem_ready = tv[i].ready;
      step();
      chk($sformatf("v%0d_valid", i), {15'd0, if_valid},
          {15'd0, tv[i].valid});
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
      if (tv[i].valid) begin
        chk($sformatf("v%0d_pc", i), if_pc, tv[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr,
            16'h1000 + tv[i].pc);
        chk($sformatf("v%0d_link", i), if_link,
            tv[i].pc + 16'd1);
      end else begin
        chk($sformatf("v%0d_nop", i), if_instr, 16'h0000);
      end
    end

    // RESET_PC near the top of memory: fetch wraps around.
    w_rst = 0;
    chk("w_addr0", w_addr, 16'hFFFE);
    step();
    chk("w_pc0", w_pc, 16'hFFFE);
    chk("w_link0", w_link, 16'hFFFF);
    chk("w_instr0", w_instr, 16'h0FFE);
    step();
    chk("w_pc1", w_pc, 16'hFFFF);
    chk("w_link1", w_link, 16'h0000);
    step();
    chk("w_pc2", w_pc, 16'h0000);
    chk("w_valid2", {15'd0, w_valid}, 16'h0001);
    // Reset while an EXEC fetch is waiting on memory.
    w_exec_req = 1; w_exec_pc = 16'h0123; w_ready = 0;
    step();
    w_exec_req = 0;
    chk("w_exec_addr", w_addr, 16'h0123);
    step();
    chk("w_exec_wait", w_addr, 16'h0123);
    w_rst = 1;
    step();
    chk("w_rst_valid", {15'd0, w_valid}, 16'h0000);
    chk("w_rst_addr", w_addr, 16'hFFFE);
    chk("w_rst_req", {15'd0, w_req}, 16'h0000);
    w_rst = 0; w_ready = 1;
    step();
    chk("w_after_pc", w_pc, 16'hFFFE);
    chk("w_after_valid", {15'd0, w_valid}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined core. Owns the program counter, drives the instruction-memory request port, and registers the fetched instruction into the IF/ID latch consumed by the decode/control stage. Applies PC hold, branch/jump redirect with squash, and the one-shot EXEC fetch-and-return sequence.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, 16'h0000: bubble encoding inserted on squash or memory wait.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `hold`  in  1  PC_HOLD from control; freezes PC and IF/ID latch.
- `redirect`  in  1  taken branch, JAL or JR resolved downstream.
- `redirect_pc`  in  16  redirect target.
- `exec_req`  in  1  EXEC issued downstream; fetch one instruction at `exec_pc`, then resume.
- `exec_pc`  in  16  EXEC target address.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  16  fetch address.
- `imem_rdata`  in  16  instruction word; valid when `imem_ready`.
- `imem_ready`  in  1  memory has `imem_rdata` for the current `imem_addr`; may stall any number of cycles.
- `if_instr`  out  16  IF/ID instruction, feeds control input.
- `if_pc`  out  16  address of `if_instr`.
- `if_link`  out  16  `if_pc + 1`, JAL link value.
- `if_valid`  out  1  `if_instr` is a real instruction, not a bubble.

## Operation
- States: FETCH (sequential fetch at `pc`) and EXEC (single fetch at the latched EXEC target).
- Per-cycle priority: `rst` > `redirect` > `exec_req` > `hold` > normal fetch.
- FETCH, normal: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ready`: latch `if_instr`=`imem_rdata`, `if_pc`=`pc`, `if_valid`=1, and set `pc`←`pc+1`.
  - Without `imem_ready`: latch `if_instr`=NOP, `if_valid`=0, and `pc` is unchanged.
- `hold`: `pc`, state and the whole IF/ID latch keep their values. `imem_req` stays 1 so memory may complete the fetch, but a completion during hold is discarded and refetched after release.
- `redirect` (either state):
  - `pc`←`redirect_pc`, state←FETCH.
  - IF/ID latch←NOP with `if_valid`=0.
  - Any pending EXEC is aborted.
- `exec_req` in FETCH:
  - Saves `ret_pc`←`pc` (the next sequential address, not yet fetched) and `exec_addr`←`exec_pc`; state←EXEC.
  - IF/ID latch←NOP, `if_valid`=0.
- EXEC: `imem_addr`=`exec_addr`. On `imem_ready`:
  - IF/ID←{`imem_rdata`, `exec_addr`, valid=1}.
  - `pc`←`ret_pc`, state←FETCH.
- `exec_req` while in EXEC is ignored; nested EXEC is unsupported.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000. `if_link` wraps the same way.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=FETCH.
  - `if_instr`=NOP, `if_pc`=16'h0000, `if_valid`=0.
  - `imem_req`=0 during the reset cycle.
  - `ret_pc` and `exec_addr` = 16'h0000.
- Fetch latency: instruction appears on `if_instr` one cycle after the cycle in which `imem_ready`=1.
- Zero-wait memory gives one instruction per cycle.
- Redirect in cycle N:
  - Cycle N+1: `if_valid`=0 and `imem_addr`=`redirect_pc`.
  - First target instruction reaches `if_instr` at N+2 at the earliest.
- `redirect` and `exec_req` in the same cycle: redirect wins and `exec_req` is dropped.
- `hold` and `redirect` in the same cycle: redirect wins.
- `rst` asserted mid-EXEC or mid-wait returns the unit to the reset values on the next edge.
- `imem_rdata` is sampled only when `imem_ready`=1. `imem_addr` is stable while waiting, unless a redirect occurs.

## Structure
- Shared package `cpu_defs`:
  - `NOP_INSTR` and the 4-bit opcode constants, shared with control.
  - Fetch state enum {FETCH, EXEC}.
  - `XLEN`=16.
- One sub-module, `fetch_pc_gen`: combinational next-PC select (seq/redirect/exec return/hold) plus the `+1` adder. FSM and IF/ID latch stay in `fetch_unit`.

## Test plan
- Reset, zero-wait memory holding words 16'h1000+addr → `if_pc` 0,1,2,3 on consecutive cycles. `if_instr` 16'h1000..16'h1003. `if_link` = `if_pc+1`.
- `imem_ready` low for 3 cycles at addr 5 → three cycles `if_valid`=0, `if_instr`=16'h0000. `imem_addr` stays 5. Then `if_pc`=5.
- `redirect`=1, `redirect_pc`=16'h0040 while fetching addr 9 → next cycle bubble. Following cycle `if_pc`=16'h0040. Addr 9 never reaches `if_valid`=1.
- `exec_req`, `exec_pc`=16'h0200, at `pc`=16'h0010 → one bubble, then `if_pc`=16'h0200 valid, then `if_pc`=16'h0010, 16'h0011 resume.
- `hold` 2 cycles with `if_pc`=7 → `if_instr`, `if_pc`, `if_valid` unchanged. After release `if_pc`=8.
- `RESET_PC`=16'hFFFE, zero-wait → `if_pc` FFFE, FFFF, 0000. `rst` during EXEC wait → state FETCH, `pc`=16'hFFFE, `if_valid`=0.
